// File: rtl/inst_fetch.sv
// inst_fetch: fetch-side initiator for a combinational instruction ROM.
// Owns the PC, presents it to the ROM every cycle, and buffers the
// returned {pc, inst} pairs in a small FIFO. ID consumes the FIFO head
// through a valid/ready handshake. A branch redirect empties the FIFO
// and reloads the PC.
module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter int          FIFO_PTR_W = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  rom_ce,
   output logic [31:0]           rom_addr,
   input  logic [31:0]           rom_inst,
   input  logic                  branch_flag,
   input  logic [31:0]           branch_target,
   input  logic                  id_ready,
   output logic                  if_valid,
   output logic [31:0]           if_pc,
   output logic [31:0]           if_inst,
   output logic [FIFO_PTR_W:0]   fifo_count
);

   localparam logic [FIFO_PTR_W:0] DEPTH_C     = (FIFO_PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [31:0]         ZERO_WORD   = 32'h0000_0000;
   localparam logic                CHIP_ENABLE = 1'b1;
   localparam logic                CHIP_DISABLE = 1'b0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [31:0]             pc_q, pc_d;
   logic [FIFO_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_PTR_W:0]     count_q, count_d;

   // FIFO storage: PC and instruction word per entry
   logic [31:0]             pc_mem_q   [FIFO_DEPTH];
   logic [31:0]             inst_mem_q [FIFO_DEPTH];

   logic                    fifo_empty;
   logic                    fifo_has_room;
   logic                    pop;
   logic                    push;
   logic                    redirect;
   logic [31:0]             redirect_pc;

   // The low two target bits never reach the PC; the redirect address
   // is always word aligned.
   logic                    unused_tgt_bits;
   assign unused_tgt_bits = ^branch_target[1:0];

   // Handshake and FIFO bookkeeping terms
   always_comb begin
      fifo_empty    = (count_q == '0);
      fifo_has_room = (count_q < DEPTH_C);
      redirect      = branch_flag;
      redirect_pc   = {branch_target[31:2], 2'b00};
      // A pop is taken whenever the head is valid and ID is ready, even
      // on a redirect cycle: that entry counts as consumed.
      pop           = !fifo_empty && id_ready;
      // A full FIFO may still accept a new word when the head leaves on
      // the same edge.
      push          = (state_q == ST_RUN) && !redirect && (fifo_has_room || pop);
   end

   // State, PC and FIFO control registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Next-state logic: FSM, PC sequencing and FIFO pointer/count updates
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      case (state_q)
         // IDLE only exists for the first cycle after reset; a redirect
         // arriving here also lands in RUN.
         ST_IDLE: state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase

      if (redirect) begin
         // Redirect wins over push and pop; the ROM word of this cycle
         // is dropped and everything buffered is discarded.
         pc_d     = redirect_pc;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(1);
            // Wrap past 32'hFFFF_FFFC back to zero is intentional.
            pc_d     = pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_PTR_W + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO entry write: capture the PC and the ROM word presented for it
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= pc_q;
         inst_mem_q[wr_ptr_q] <= rom_inst;
      end
   end

   // ROM interface and head-of-FIFO presentation to ID
   always_comb begin
      rom_ce     = (state_q == ST_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
      rom_addr   = pc_q;
      if_valid   = !fifo_empty;
      fifo_count = count_q;
      if_pc      = ZERO_WORD;
      if_inst    = ZERO_WORD;
      if (!fifo_empty) begin
         if_pc   = pc_mem_q[rd_ptr_q];
         if_inst = inst_mem_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a
// queue-based behavioural model of the fetch buffer.
module tb_inst_fetch;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [1:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] m_pc;
   logic        m_run;
   logic [31:0] q_pc[$];
   logic [31:0] q_inst[$];

   inst_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2),
      .FIFO_PTR_W (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rom_ce        (rom_ce),
      .rom_addr      (rom_addr),
      .rom_inst      (rom_inst),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .id_ready      (id_ready),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_inst       (if_inst),
      .fifo_count    (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: the four test words at 0..C, a scrambled word elsewhere
   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      case (a)
         32'h0: return 32'h3401_1100;
         32'h4: return 32'h3402_0020;
         32'h8: return 32'h3403_ff00;
         32'hC: return 32'h3404_ffff;
         default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
      endcase
   endfunction

   assign rom_inst = rom_fn(rom_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pc  = 32'h0;
      m_run = 1'b0;
      q_pc.delete();
      q_inst.delete();
   endtask

   // Model of one rising edge, using the values present before the edge
   task automatic m_edge(input logic rdy, input logic br, input logic [31:0] tgt);
      int  sz;
      logic popped;
      if (br) begin
         q_pc.delete();
         q_inst.delete();
         m_pc  = tgt & 32'hFFFF_FFFC;
         m_run = 1'b1;
      end else begin
         sz     = q_pc.size();
         popped = (sz != 0) && rdy;
         if (popped) begin
            void'(q_pc.pop_front());
            void'(q_inst.pop_front());
         end
         if (m_run && (sz < DEPTH || popped)) begin
            q_pc.push_back(m_pc);
            q_inst.push_back(rom_fn(m_pc));
            m_pc = m_pc + 32'd4;
         end
         m_run = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] e_pc, e_inst;
      e_pc   = (q_pc.size() != 0) ? q_pc[0] : 32'h0;
      e_inst = (q_inst.size() != 0) ? q_inst[0] : 32'h0;
      check({tag, ".rom_ce"},   {31'b0, rom_ce},      {31'b0, m_run});
      check({tag, ".rom_addr"}, rom_addr,             m_pc);
      check({tag, ".if_valid"}, {31'b0, if_valid},    {31'b0, (q_pc.size() != 0)});
      check({tag, ".if_pc"},    if_pc,                e_pc);
      check({tag, ".if_inst"},  if_inst,              e_inst);
      check({tag, ".count"},    {30'b0, fifo_count},  32'(q_pc.size()));
   endtask

   task automatic step(input string tag, input logic rdy, input logic br, input logic [31:0] tgt);
      id_ready      = rdy;
      branch_flag   = br;
      branch_target = tgt;
      @(posedge clk);
      #1;
      m_edge(rdy, br, tgt);
      check_all(tag);
      $display("step %s rdy=%0b br=%0b tgt=%h -> addr=%h valid=%0b pc=%h inst=%h cnt=%0d",
               tag, rdy, br, tgt, rom_addr, if_valid, if_pc, if_inst, fifo_count);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      m_reset();
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic        r, b;
      logic [31:0] t;

      rst           = 1'b0;
      id_ready      = 1'b0;
      branch_flag   = 1'b0;
      branch_target = 32'h0;
      m_reset();
      #2;
      check_all("por");
      @(negedge clk);
      rst = 1'b1;

      // Streaming from reset with ID always ready
      step("stream", 1'b1, 1'b0, 32'h0);
      check("first_ce", {31'b0, rom_ce}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         step("stream", 1'b1, 1'b0, 32'h0);
         if (i < 4) begin
            check("stream_pc", if_pc, 32'(i * 4));
         end
      end

      // ID stalled: buffer fills, PC freezes at 8
      do_reset();
      for (int i = 0; i < 5; i++) step("stall", 1'b0, 1'b0, 32'h0);
      check("stall_cnt",  {30'b0, fifo_count}, 32'd2);
      check("stall_addr", rom_addr, 32'h8);
      check("stall_inst", if_inst, 32'h3401_1100);
      // Full FIFO with simultaneous pop and push
      step("fullpp", 1'b1, 1'b0, 32'h0);
      check("fullpp_cnt",  {30'b0, fifo_count}, 32'd2);
      check("fullpp_addr", rom_addr, 32'hC);
      check("fullpp_head", if_pc, 32'h4);
      for (int i = 0; i < 3; i++) step("drain", 1'b1, 1'b0, 32'h0);

      // Redirect while full, ID stalled
      for (int i = 0; i < 3; i++) step("fill", 1'b0, 1'b0, 32'h0);
      step("br13", 1'b0, 1'b1, 32'h0000_0013);
      check("br_cnt",  {30'b0, fifo_count}, 32'd0);
      check("br_addr", rom_addr, 32'h10);
      step("br13b", 1'b0, 1'b0, 32'h0);
      check("br_head", if_pc, 32'h10);

      // Back-to-back redirects
      step("b2b1", 1'b1, 1'b1, 32'h0000_0100);
      step("b2b2", 1'b1, 1'b1, 32'h0000_0207);
      check("b2b_cnt",  {30'b0, fifo_count}, 32'd0);
      check("b2b_addr", rom_addr, 32'h204);

      // PC wrap past the top of the address space
      step("wrap", 1'b1, 1'b1, 32'hFFFF_FFFC);
      step("wrap", 1'b1, 1'b0, 32'h0);
      check("wrap_pc0", if_pc, 32'hFFFF_FFFC);
      step("wrap", 1'b1, 1'b0, 32'h0);
      check("wrap_pc1", if_pc, 32'h0000_0000);

      // Partial-cycle reset mid-stream
      step("pre_rst", 1'b1, 1'b0, 32'h0);
      #2;
      rst = 1'b0;
      #1;
      m_reset();
      check_all("async_rst");
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step("restart", 1'b1, 1'b0, 32'h0);
      check("restart_pc", if_pc, 32'h4);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = 1'($urandom_range(0, 3) != 0);
         b = 1'($urandom_range(0, 9) == 0);
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom);
         step("rand", r, b, t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch-side initiator for the combinational instruction ROM.
- Owns the PC and drives the ROM chip-enable and byte address each cycle.
- Captures the returned instruction word together with its PC into a small FIFO.
- Presents the FIFO head to ID through a valid/ready handshake; branch redirects from ID/EX flush the FIFO and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, number of {pc, inst} entries buffered (power of two, ≥2).
- FIFO_PTR_W, 1, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce  output  1  ROM chip enable; ChipEnable while fetching.
- rom_addr  output  32  byte address to ROM; always equals the PC register.
- rom_inst  input  32  instruction returned combinationally by ROM in the same cycle as rom_addr.
- branch_flag  input  1  redirect request; sampled on rising edge.
- branch_target  input  32  redirect address; bits [1:0] ignored (forced to 0).
- id_ready  input  1  ID accepts the head entry this cycle.
- if_valid  output  1  head entry present.
- if_pc  output  32  PC of head entry.
- if_inst  output  32  instruction of head entry.
- fifo_count  output  FIFO_PTR_W+1  current occupancy, for debug and stall visibility.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, rom_ce=ChipDisable.
  - FIFO empty (rd/wr pointers 0, count 0).
  - if_valid=0, if_pc=0, if_inst=ZeroWord.
- States:
  - IDLE: rom_ce=0. Entered only on reset. Unconditional move to RUN on the first rising edge with rst=1.
  - RUN: rom_ce=1 for all remaining time.
- rom_addr=pc combinationally in every state, including IDLE.
- pop: if_valid && id_ready.
- push: state==RUN && !branch_flag && (count<FIFO_DEPTH || pop).
  - Push writes {pc, rom_inst} at wr_ptr.
  - pc <= pc+4. The 32-bit wrap 32'hFFFF_FFFC→0 is legal and unflagged.
- No push (FIFO full, no pop): pc holds, rom_ce stays 1, and the same address is re-presented next cycle.
- Redirect (branch_flag=1 on an edge, RUN or IDLE):
  - FIFO cleared (count=0, pointers 0).
  - pc <= {branch_target[31:2], 2'b00}.
  - rom_inst of that cycle is discarded.
  - Takes priority over push and pop; a simultaneous pop is treated as accepted and not re-issued.
  - If asserted in IDLE, the state also moves to RUN.
- Back-to-back redirects: each one reloads the PC and the FIFO stays empty.
- Output timing:
  - if_valid = (count!=0). Same-cycle simultaneous push and pop keep count unchanged.
  - if_pc/if_inst are driven from the head entry when count!=0, else 0.
  - Latency: instruction at PC X is visible on if_* the cycle after X is on rom_addr, provided no redirect occurs and the FIFO is not full.
  - Steady state with id_ready=1 gives one instruction per cycle.
- ID must hold id_ready independent of if_valid. if_* must stay stable while if_valid && !id_ready.
- Reset asserted mid-run: immediate return to reset values; all FIFO contents lost.

Test Plan:
- Reset release, ROM = {34011100, 34020020, 3403ff00, 3404ffff}, id_ready=1:
  - rom_ce=1 one edge after release.
  - if_valid sequence pc 0,4,8,C with those words on consecutive cycles.
- id_ready=0 after reset:
  - count rises to 2, then pc freezes at 8 and rom_addr stays 8.
  - if_pc holds 0, if_inst 34011100.
  - Raising id_ready drains in order 0,4,8 with no gaps or duplicates.
- FIFO full with pop and push on the same edge:
  - count stays 2 and pc advances by 4.
  - Next head is the former second entry.
- branch_flag=1, branch_target=32'h0000_0013 while count=2:
  - Next cycle count=0, if_valid=0, rom_addr=32'h10.
  - Following cycle if_pc=32'h10.
- rst pulsed low for a partial cycle mid-stream:
  - Outputs return to reset values asynchronously.
  - After release, fetch restarts at RESET_PC.
- pc preloaded via redirect to 32'hFFFF_FFFC, id_ready=1:
  - Consecutive if_pc values are FFFF_FFFC then 0000_0000.
